// File: rtl/nishit_param_counter.sv
// Parameterised up/down counter with prescaler, runtime terminal value,
// four terminal behaviours (wrap, saturate, one-shot, ping-pong) and compare flag.
module nishit_param_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      top,
    input  logic [PRESCALE_W-1:0] div,
    input  logic [WIDTH-1:0]      cmp_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  done,
    output logic                  cmp_match
);

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] pre_nxt;
    logic                  tick_c;
    logic                  pp_dir;
    logic                  pp_dir_nxt;
    logic                  d_c;
    logic                  at_term_c;
    logic [WIDTH-1:0]      count_nxt;
    logic                  tc_nxt;
    logic                  done_nxt;

    assign cmp_match = (count == cmp_val);

    // Prescaler: one tick every div+1 enabled cycles, phase frozen while en=0.
    always_comb begin
        tick_c  = en && (pre == div);
        pre_nxt = pre;
        if (load) begin
            pre_nxt = '0;
        end else if (en) begin
            pre_nxt = tick_c ? '0 : pre + PRESCALE_W'(1);
        end
    end

    // Direction and terminal detection; loaded values above top count as terminal.
    always_comb begin
        d_c       = (mode == MODE_PINGPONG) ? pp_dir : dir;
        at_term_c = d_c ? (count >= top) : (count == '0);
    end

    // Next count, direction, flags.
    always_comb begin
        count_nxt  = count;
        pp_dir_nxt = pp_dir;
        done_nxt   = done;
        tc_nxt     = 1'b0;
        if (load) begin
            count_nxt  = load_val;
            pp_dir_nxt = dir;
            done_nxt   = 1'b0;
        end else if (tick_c && !done) begin
            if (!at_term_c) begin
                count_nxt = d_c ? count + WIDTH'(1) : count - WIDTH'(1);
            end else begin
                tc_nxt = 1'b1;
                case (mode)
                    MODE_WRAP:     count_nxt = d_c ? '0 : top;
                    MODE_SATURATE: count_nxt = count;
                    MODE_ONESHOT:  done_nxt  = 1'b1;
                    MODE_PINGPONG: begin
                        pp_dir_nxt = ~pp_dir;
                        // Step in the reversed direction unless that would leave [0, top].
                        if (!pp_dir) begin
                            if (count < top) count_nxt = count + WIDTH'(1);
                        end else begin
                            if (count != '0) count_nxt = count - WIDTH'(1);
                        end
                    end
                    default:       count_nxt = count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            tc     <= 1'b0;
            done   <= 1'b0;
            pre    <= '0;
            pp_dir <= 1'b1;
        end else begin
            count  <= count_nxt;
            tc     <= tc_nxt;
            done   <= done_nxt;
            pre    <= pre_nxt;
            pp_dir <= pp_dir_nxt;
        end
    end

endmodule

// File: tb/tb_nishit_param_counter.sv
// Directed + randomized bench for nishit_param_counter against an integer reference model.
module tb_nishit_param_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst, en, load, dir;
    logic [1:0]    mode;
    logic [W-1:0]  load_val, top, cmp_val;
    logic [PW-1:0] div;
    logic [W-1:0]  count;
    logic          tc, done, cmp_match;

    int n_vec = 0;
    int n_err = 0;

    // Reference state as plain integers.
    int m_count, m_pre, m_tc, m_done, m_pp;

    nishit_param_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .dir(dir), .mode(mode), .top(top), .div(div), .cmp_val(cmp_val),
        .count(count), .tc(tc), .done(done), .cmp_match(cmp_match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the reference by one clock using the currently driven inputs.
    task automatic model_edge();
        int  d;
        int  t;
        bit  tick;
        bit  at;
        t = int'(top);
        if (rst) begin
            m_count = 0; m_tc = 0; m_done = 0; m_pre = 0; m_pp = 1;
        end else if (load) begin
            m_count = int'(load_val); m_pre = 0; m_done = 0; m_tc = 0; m_pp = int'(dir);
        end else begin
            m_tc = 0;
            tick = en && (m_pre == int'(div));
            if (en) m_pre = tick ? 0 : m_pre + 1;
            if (tick && m_done == 0) begin
                d  = (mode == 2'd3) ? m_pp : int'(dir);
                at = (d == 1) ? (m_count >= t) : (m_count == 0);
                if (!at) begin
                    m_count = (d == 1) ? m_count + 1 : m_count - 1;
                end else begin
                    m_tc = 1;
                    if (mode == 2'd0)      m_count = (d == 1) ? 0 : t;
                    else if (mode == 2'd2) m_done = 1;
                    else if (mode == 2'd3) begin
                        m_pp = 1 - m_pp;
                        if (m_pp == 1 && m_count + 1 <= t) m_count = m_count + 1;
                        else if (m_pp == 0 && m_count > 0) m_count = m_count - 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_count));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("done", 32'(done), 32'(m_done));
        chk("cmp_match", 32'(cmp_match), (m_count == int'(cmp_val)) ? 32'd1 : 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b1; mode = 2'd0;
        load_val = '0; top = 8'd5; div = '0; cmp_val = 8'd3;
        m_count = 0; m_pre = 0; m_tc = 0; m_done = 0; m_pp = 1;

        // Reset
        run(2);
        chk("reset_count", 32'(count), 32'd0);

        // Wrap up, top=5
        rst = 1'b0; en = 1'b1;
        run(8);

        // Prescaler div=2, with en dropped for 4 cycles
        top = 8'd255; div = 8'd2;
        do_load(8'd0);
        run(7);
        en = 1'b0; run(4);
        en = 1'b1; run(6);

        // Saturate down, then a load above top
        mode = 2'd1; dir = 1'b0; div = '0;
        do_load(8'd3);
        run(6);
        dir = 1'b1; top = 8'd10;
        do_load(8'd200);
        run(4);
        chk("sat_above_top", 32'(count), 32'd200);
        chk("sat_tc", 32'(tc), 32'd1);

        // One-shot
        mode = 2'd2; top = 8'd3;
        do_load(8'd0);
        run(8);
        chk("oneshot_done", 32'(done), 32'd1);
        chk("oneshot_hold", 32'(count), 32'd3);
        do_load(8'd0);
        chk("oneshot_cleared", 32'(done), 32'd0);
        run(3);

        // Ping-pong, then top=0
        mode = 2'd3; dir = 1'b1; top = 8'd3;
        do_load(8'd0);
        run(10);
        top = 8'd0;
        do_load(8'd0);
        run(4);
        chk("pp_top0", 32'(count), 32'd0);

        // Load beats tick; reset beats load
        mode = 2'd0; top = 8'd255; div = '0; dir = 1'b1;
        do_load(8'd7);
        chk("prio_load", 32'(count), 32'd7);
        do_load(8'd0);
        run(4);
        chk("pre_rst_count", 32'(count), 32'd4);
        div = 8'd2; rst = 1'b1; load = 1'b1; load_val = 8'd9;
        cycle();
        rst = 1'b0; load = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        run(7);

        // Randomized segments, mode fixed per segment and entered via load
        for (int s = 0; s < 40; s++) begin
            mode = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
            top  = 8'($urandom_range(0, 12));
            div  = 8'($urandom_range(0, 2));
            en   = 1'b1;
            do_load(8'($urandom_range(0, 14)));
            for (int c = 0; c < 25; c++) begin
                en      = ($urandom_range(0, 9) < 8);
                cmp_val = 8'($urandom_range(0, 12));
                if ($urandom_range(0, 9) == 0) dir = ~dir;
                if ($urandom_range(0, 14) == 0) top = 8'($urandom_range(0, 12));
                if ($urandom_range(0, 19) == 0) div = 8'($urandom_range(0, 3));
                load     = ($urandom_range(0, 19) == 0);
                load_val = 8'($urandom_range(0, 14));
                rst      = ($urandom_range(0, 99) == 0);
                cycle();
                load = 1'b0; rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
